// File: rtl/axi_ddr_burst_master.sv
// Single-burst AXI4 master: one command becomes one INCR burst on AW/W/B or AR/R,
// with local write/read beat streams passed straight through to the AXI data channels.
module axi_ddr_burst_master #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_AXI_ID           = 0
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                    cmd_len,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          done,
  output logic                          err,
  output logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FIN} state_e;

  typedef struct packed {
    logic [C_S_AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                    len;
  } cmd_t;

  state_e state_q;
  cmd_t   cmd_q;
  logic [7:0] cnt_q;
  logic   err_q;
  logic   axvalid_q;
  logic   live_q;

  logic [13:0] end_off;
  logic        cmd_bad, cmd_acc, w_beat, r_beat, beat_last;
  logic        unused_ids;

  // Burst end offset within its 4 KB page; exactly 4096 is still legal.
  assign end_off  = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign cmd_bad  = (cmd_addr[1:0] != 2'b00) || (end_off > 14'd4096);
  assign cmd_acc  = cmd_valid && cmd_ready;
  assign beat_last = (cnt_q == cmd_q.len);
  assign w_beat   = (state_q == S_W) && wr_valid && m_axi_wready;
  assign r_beat   = (state_q == S_R) && m_axi_rvalid && rd_ready;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // live_q keeps cmd_ready low while reset is held and for the release edge.
  assign cmd_ready = live_q && (state_q == S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err       = (state_q == S_FIN) && err_q;

  assign m_axi_awid    = C_S_AXI_ID_WIDTH'(C_AXI_ID);
  assign m_axi_awaddr  = cmd_q.addr;
  assign m_axi_awlen   = cmd_q.len;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = axvalid_q && (state_q == S_AW);

  assign m_axi_arid    = C_S_AXI_ID_WIDTH'(C_AXI_ID);
  assign m_axi_araddr  = cmd_q.addr;
  assign m_axi_arlen   = cmd_q.len;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = axvalid_q && (state_q == S_AR);

  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wvalid = (state_q == S_W) && wr_valid;
  assign m_axi_wlast  = (state_q == S_W) && beat_last;
  assign wr_ready     = (state_q == S_W) && m_axi_wready;
  assign m_axi_bready = (state_q == S_B);

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = (state_q == S_R) && m_axi_rvalid;
  assign m_axi_rready = (state_q == S_R) && rd_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      axvalid_q <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: if (cmd_acc) begin
          cmd_q <= '{addr: cmd_addr, len: cmd_len};
          cnt_q <= '0;
          if (cmd_bad) begin
            err_q   <= 1'b1;
            state_q <= S_FIN;
          end else begin
            axvalid_q <= 1'b1;
            state_q   <= cmd_write ? S_AW : S_AR;
          end
        end
        S_AW: if (m_axi_awready) begin
          axvalid_q <= 1'b0;
          state_q   <= S_W;
        end
        S_W: if (w_beat) begin
          if (beat_last) begin
            cnt_q   <= '0;
            state_q <= S_B;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_B: if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_q <= 1'b1;
          state_q <= S_FIN;
        end
        S_AR: if (m_axi_arready) begin
          axvalid_q <= 1'b0;
          state_q   <= S_R;
        end
        S_R: if (r_beat) begin
          // Bad response or rlast out of place with the expected count both fail the command.
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != beat_last)) err_q <= 1'b1;
          if (m_axi_rlast || beat_last) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_FIN: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ddr_burst_master.sv
// Directed bench: a table of burst commands run against a small AXI slave responder,
// plus a hand-written reset-mid-burst sequence.
module tb_axi_ddr_burst_master;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, done, err;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, awqos, arcache, arqos, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_ddr_burst_master dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    int          dly;        // cycles of awvalid/arvalid before ready
    logic [1:0]  bresp_v;
    int          bad_beat;   // read beat carrying rresp=SLVERR, -1 none
    int          early_last; // read beat carrying an early rlast, -1 none
    logic        no_last;    // never drive rlast
    int          rst_beat;   // write beat index at which reset is pulsed, -1 none
    logic        exp_axi;
    logic        exp_err;
    int          exp_beats;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  vec_t vecs[12];
  logic rst_hit;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [7:0] l, int dly, logic [1:0] br,
                              int bb, int el, logic nl, int rb, logic ea, logic ee, int eb);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.dly = dly; v.bresp_v = br; v.bad_beat = bb;
    v.early_last = el; v.no_last = nl; v.rst_beat = rb; v.exp_axi = ea; v.exp_err = ee;
    v.exp_beats = eb;
    return v;
  endfunction

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rd_ready = 0; wr_valid = 0; wr_data = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_valids"}, {awvalid, arvalid, wvalid, rd_valid, done, err}, 0);
    chk({tag, "_readys"}, {wr_ready, bready, rready}, 0);
  endtask

  // Entered and left at posedge+1; drives the command, then plays the slave until done.
  task automatic run(input vec_t v, input string nm);
    int cyc = 0, aw_wait = 0, wb = 0, rs = 0, nb;
    logic aw_done = 0, b_done = 0, early_w = 0, saw_axi = 0, fin = 0;
    nb = (v.early_last >= 0) ? v.early_last + 1 : v.len + 1;
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk({nm, "_cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0;
    while (!fin) begin
      awready  = !aw_done && (aw_wait >= v.dly);
      arready  = awready;
      wr_valid = 1; wr_data = 32'hA000_0000 + wb;
      wready   = (cyc % 3 != 2);
      bvalid   = v.wr && aw_done && (wb == v.len + 1) && !b_done;
      bresp    = v.bresp_v;
      rvalid   = !v.wr && aw_done && (rs < nb);
      rdata    = 32'hB000_0000 + rs;
      rresp    = (rs == v.bad_beat) ? 2'b10 : 2'b00;
      rlast    = !v.no_last && rvalid && (rs == nb - 1);
      rd_ready = cyc[0];
      #1;
      if (cyc == 0) chk({nm, "_axvalid_next"}, awvalid | arvalid, v.exp_axi);
      if (awvalid | arvalid) saw_axi = 1;
      if (wvalid && !aw_done) early_w = 1;
      if ((awvalid && awready) || (arvalid && arready)) begin
        chk({nm, "_ax_addr"}, v.wr ? awaddr : araddr, v.addr);
        chk({nm, "_ax_len"}, v.wr ? awlen : arlen, v.len);
        chk({nm, "_ax_const"}, v.wr ? {awsize, awburst, awlock, awcache, awprot, awqos}
                                    : {arsize, arburst, arlock, arcache, arprot, arqos},
            {3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
        aw_done = 1;
      end else if (awvalid | arvalid) aw_wait++;
      if (v.rst_beat >= 0 && wvalid && wb == v.rst_beat) begin
        aresetn = 0;
        #1 zero_outs({nm, "_async"});
        rst_hit = 1;
        return;
      end
      if (wvalid && wready) begin
        chk({nm, "_wdata"}, wdata, 32'hA000_0000 + wb);
        chk({nm, "_wlast"}, {wlast, wstrb}, {(wb == v.len), 4'hF});
        chk({nm, "_wr_ready"}, wr_ready, 1);
        wb++;
      end
      if (bvalid) begin
        chk({nm, "_bready"}, bready, 1);
        b_done = 1;
      end
      if (rvalid) chk({nm, "_rpass"}, {rd_valid, rready}, {1'b1, rd_ready});
      if (rvalid && rd_ready) begin
        chk({nm, "_rd_data"}, rd_data, 32'hB000_0000 + rs);
        rs++;
      end
      if (done) begin
        chk({nm, "_err"}, err, v.exp_err);
        chk({nm, "_beats"}, v.wr ? wb : rs, v.exp_beats);
        chk({nm, "_axi_seen"}, saw_axi, v.exp_axi);
        chk({nm, "_w_before_aw"}, early_w, 0);
        if (!v.exp_axi) chk({nm, "_fast_fin"}, cyc <= 1, 1);
        fin = 1;
      end else if (cyc > 3000) begin
        chk({nm, "_timeout"}, 0, 1);
        fin = 1;
      end
      cyc++;
      tick();
    end
    slave_idle();
    #1;
    chk({nm, "_done_1cyc"}, {done, err}, 0);
    chk({nm, "_idle_ready"}, cmd_ready, 1);
  endtask

  initial begin
    vecs[0]  = mk(1, 32'hBC00_0000, 7,   3, 0, -1, -1, 0, -1, 1, 0, 8);
    vecs[1]  = mk(0, 32'hBC00_0100, 3,   0, 0, -1, -1, 0, -1, 1, 0, 4);
    vecs[2]  = mk(1, 32'hBC00_0FF0, 7,   0, 0, -1, -1, 0, -1, 0, 1, 0);
    vecs[3]  = mk(0, 32'hBC00_0200, 3,   1, 0,  1, -1, 0, -1, 1, 1, 4);
    vecs[4]  = mk(0, 32'hBC00_0300, 3,   0, 0, -1,  1, 0, -1, 1, 1, 2);
    vecs[5]  = mk(0, 32'hBC00_0002, 0,   0, 0, -1, -1, 0, -1, 0, 1, 0);
    vecs[6]  = mk(1, 32'hBC00_0400, 0,   2, 2, -1, -1, 0, -1, 1, 1, 1);
    vecs[7]  = mk(1, 32'hBC00_0FC0, 15,  0, 0, -1, -1, 0, -1, 1, 0, 16);
    vecs[8]  = mk(0, 32'hBC00_0FC4, 15,  0, 0, -1, -1, 0, -1, 0, 1, 0);
    vecs[9]  = mk(0, 32'hBC00_0000, 255, 0, 0, -1, -1, 0, -1, 1, 0, 256);
    vecs[10] = mk(0, 32'hBC00_0500, 2,   0, 0, -1, -1, 1, -1, 1, 1, 3);
    vecs[11] = mk(1, 32'hBC00_0600, 15,  0, 0, -1, -1, 0,  2, 1, 0, 0);

    rst_hit = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    bid = 0; rid = 0;
    slave_idle();
    aresetn = 0;
    #12 zero_outs("reset");
    tick();
    aresetn = 1;
    tick();
    chk("post_reset_ready", cmd_ready, 1);

    for (int i = 0; i < 11; i++) run(vecs[i], $sformatf("v%0d", i));

    // Reset pulsed during W beat 2 of a 16-beat write.
    run(vecs[11], "rst");
    chk("rst_reached", rst_hit, 1);
    if (!rst_hit) aresetn = 0;
    slave_idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      zero_outs($sformatf("rst_hold%0d", i));
    end
    @(negedge clk);
    aresetn = 1;
    tick();
    chk("rst_release_ready", cmd_ready, 1);
    chk("rst_no_done", done, 0);
    run(vecs[1], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
